// File: rtl/display_pkg.sv
// Shared raster timing definitions: coordinate width, per-mode timing sets
// and helpers that turn porch/sync/active widths into signed coordinates.
package display_pkg;

    localparam int CORDW = 16;

    typedef struct packed {
        int h_res;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_res;
        int v_fp;
        int v_sync;
        int v_bp;
        bit h_pol;
        bit v_pol;
    } mode_t;

    // 640x480 at 60 Hz, 25.175 MHz pixel clock, negative syncs.
    localparam mode_t MODE_640X480P60 = '{
        h_res: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_res: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // 1280x720 at 60 Hz, 74.25 MHz pixel clock, positive syncs.
    localparam mode_t MODE_1280X720P60 = '{
        h_res: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_res: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        h_pol: 1'b1, v_pol: 1'b1
    };

    // Blanking is placed at negative coordinates, so each axis starts at
    // minus the total blanking width and ends at the last active pixel.
    function automatic int axis_start(input int fp, input int sync, input int bp);
        return -(fp + sync + bp);
    endfunction

    function automatic int axis_end(input int res);
        return res - 1;
    endfunction

    function automatic int axis_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

    // First coordinate of the sync pulse (front porch comes first).
    function automatic int sync_first(input int fp, input int sync, input int bp);
        return axis_start(fp, sync, bp) + fp;
    endfunction

    // First coordinate after the sync pulse (exclusive bound).
    function automatic int sync_after(input int fp, input int sync, input int bp);
        return sync_first(fp, sync, bp) + sync;
    endfunction

endpackage

// File: rtl/display_timings.sv
// Raster timing generator. Free-running signed pixel/line counters with
// registered sync, data-enable and strobe outputs that always describe the
// coordinates present on the same cycle.
module display_timings
    import display_pkg::*;
#(
    parameter int CORDW  = display_pkg::CORDW,
    parameter int H_RES  = MODE_640X480P60.h_res,
    parameter int H_FP   = MODE_640X480P60.h_fp,
    parameter int H_SYNC = MODE_640X480P60.h_sync,
    parameter int H_BP   = MODE_640X480P60.h_bp,
    parameter int V_RES  = MODE_640X480P60.v_res,
    parameter int V_FP   = MODE_640X480P60.v_fp,
    parameter int V_SYNC = MODE_640X480P60.v_sync,
    parameter int V_BP   = MODE_640X480P60.v_bp,
    parameter bit H_POL  = MODE_640X480P60.h_pol,
    parameter bit V_POL  = MODE_640X480P60.v_pol
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    o_hs,
    output logic                    o_vs,
    output logic                    o_de,
    output logic                    o_frame,
    output logic                    o_line,
    output logic signed [CORDW-1:0] o_sx,
    output logic signed [CORDW-1:0] o_sy
);

    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(axis_start(H_FP, H_SYNC, H_BP));
    localparam logic signed [CORDW-1:0] H_END  = CORDW'(axis_end(H_RES));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(sync_first(H_FP, H_SYNC, H_BP));
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(sync_after(H_FP, H_SYNC, H_BP));

    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(axis_start(V_FP, V_SYNC, V_BP));
    localparam logic signed [CORDW-1:0] V_END  = CORDW'(axis_end(V_RES));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(sync_first(V_FP, V_SYNC, V_BP));
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(sync_after(V_FP, V_SYNC, V_BP));

    localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

    logic signed [CORDW-1:0] sx_n;
    logic signed [CORDW-1:0] sy_n;
    logic                    hs_n;
    logic                    vs_n;
    logic                    de_n;
    logic                    line_n;
    logic                    frame_n;

    // Next coordinates: sx wraps at the end of the active line, sy only
    // advances on that wrap and itself wraps at the last active line.
    always_comb begin
        sx_n = o_sx + ONE;
        sy_n = o_sy;
        if (o_sx == H_END) begin
            sx_n = H_STA;
            if (o_sy == V_END) begin
                sy_n = V_STA;
            end else begin
                sy_n = o_sy + ONE;
            end
        end
    end

    // Decode the flags from the next coordinates so that, once registered,
    // they line up with the registered coordinates with no extra latency.
    always_comb begin
        hs_n    = (sx_n >= HS_STA) && (sx_n < HS_END);
        vs_n    = (sy_n >= VS_STA) && (sy_n < VS_END);
        de_n    = !sx_n[CORDW-1] && !sy_n[CORDW-1];
        line_n  = (sx_n == H_STA);
        frame_n = (sx_n == H_STA) && (sy_n == V_STA);
    end

    // Coordinate and output registers; reset parks the raster at the first
    // blanking pixel with every strobe and sync inactive.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sx    <= H_STA;
            o_sy    <= V_STA;
            o_hs    <= ~H_POL;
            o_vs    <= ~V_POL;
            o_de    <= 1'b0;
            o_line  <= 1'b0;
            o_frame <= 1'b0;
        end else begin
            o_sx    <= sx_n;
            o_sy    <= sy_n;
            o_hs    <= hs_n ? H_POL : ~H_POL;
            o_vs    <= vs_n ? V_POL : ~V_POL;
            o_de    <= de_n;
            o_line  <= line_n;
            o_frame <= frame_n;
        end
    end

endmodule
